// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin frame arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int ARB_N_REQ     = 4;
    localparam int ARB_DATA_W    = 8;
    localparam int ARB_MAX_BEATS = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int N_REQ = ARB_N_REQ,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_any,
    output logic [IW-1:0]    o_idx
);

    logic [N_REQ-1:0] w_rot;
    logic [IW-1:0]    w_off;

    // N_REQ is a power of two, so the IW-bit index sum wraps for free.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign w_rot[gi] = i_req[IW'(gi) + i_ptr];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_off + i_ptr;

endmodule

// File: rtl/pkt_arbiter.sv
// Frame-locked round-robin arbiter: one source owns the shared port until last beat or beat cap.
module pkt_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ     = ARB_N_REQ,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MAX_BEATS = ARB_MAX_BEATS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [$clog2(N_REQ)-1:0]  out_src,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CAP_CNT = CW'(MAX_BEATS - 1);

    arb_state_e       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gnt;
    logic [CW-1:0]    r_beat_cnt;

    logic             w_pick_any;
    logic [IW-1:0]    w_pick_idx;
    logic             w_xfer;
    logic             w_accept;
    logic [DATA_W-1:0] w_src_data [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_src_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    assign w_xfer    = (r_state == XFER);
    assign out_valid = w_xfer & req_valid[r_gnt];
    assign out_data  = w_xfer ? w_src_data[r_gnt] : '0;
    // A cap-forced end looks exactly like a source-driven last to the consumer.
    assign out_last  = w_xfer & (req_last[r_gnt] | (r_beat_cnt == CAP_CNT));
    assign out_src   = r_gnt;
    assign busy      = w_xfer;
    assign w_accept  = out_valid & out_ready;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[r_gnt] = out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt      <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        if (out_last) begin
                            r_ptr   <= r_gnt + IW'(1);
                            r_state <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed self-checking bench for pkt_arbiter (N_REQ=4, DATA_W=8, MAX_BEATS=16).
module tb_pkt_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_arbiter #(
        .N_REQ     (4),
        .DATA_W    (8),
        .MAX_BEATS (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
        req_valid[s]      = v;
        req_data[s*8 +: 8] = d;
        req_last[s]       = l;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] src, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_busy"},  {31'd0, busy},      32'd1);
        chk({tag, "_src"},   {30'd0, out_src},   {30'd0, src});
        chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
    endtask

    initial begin
        int idx;
        int c;
        int b;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_last",  {31'd0, out_last},  32'd0);
        chk("rst_src",   {30'd0, out_src},   32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);

        // All four sources hold 1-beat frames: expect 0,1,2,3,0 with an idle cycle between.
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) set_src(s, 1'b1, 8'h10 + 8'(s), 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1 chk_idle("rr_idle");
            step();
            #1 chk_beat("rr_beat", 2'(k % 4), 8'h10 + 8'(k % 4), 1'b1);
            chk("rr_req_ready", {28'd0, req_ready}, {28'd0, 4'(1 << (k % 4))});
            step();
        end
        req_valid = '0;
        req_last  = '0;

        // Single source 2, three beats.
        set_src(2, 1'b1, 8'hA1, 1'b0);
        #1 chk_idle("single_idle");
        step();
        for (int k = 0; k < 3; k++) begin
            set_src(2, 1'b1, 8'hA1 + 8'(k), k == 2);
            #1 chk_beat("single_beat", 2'd2, 8'hA1 + 8'(k), k == 2);
            chk("single_req_ready", {28'd0, req_ready}, 32'h4);
            step();
        end
        set_src(2, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("single_after");

        // Backpressure on a 4-beat frame from source 1, out_ready = 1,0,0,1,...
        set_src(1, 1'b1, 8'hB0, 1'b0);
        #1 chk_idle("bp_idle");
        step();
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 20) begin
            out_ready = (c % 3 == 0);
            set_src(1, 1'b1, 8'hB0 + 8'(idx), idx == 3);
            #1 chk_beat("bp_beat", 2'd1, 8'hB0 + 8'(idx), idx == 3);
            chk("bp_req_ready", {28'd0, req_ready}, out_ready ? 32'h2 : 32'h0);
            if (out_ready) idx++;
            c++;
            step();
        end
        chk("bp_done", idx, 32'd4);
        out_ready = 1'b1;
        set_src(1, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("bp_after");

        // 20-beat frame from source 3 is split at the 16-beat cap.
        b = 0;
        for (int f = 0; f < 2; f++) begin
            set_src(3, 1'b1, 8'hC0 + 8'(b), b == 19);
            #1 chk_idle("cap_idle");
            step();
            for (int j = 0; j < ((f == 0) ? 16 : 4); j++) begin
                set_src(3, 1'b1, 8'hC0 + 8'(b), b == 19);
                #1 chk_beat("cap_beat", 2'd3, 8'hC0 + 8'(b), (b == 15) || (b == 19));
                step();
                b++;
            end
        end
        set_src(3, 1'b0, 8'h00, 1'b0);

        // Source 0 stalls mid-frame while source 2 waits.
        set_src(0, 1'b1, 8'hD0, 1'b0);
        set_src(2, 1'b1, 8'hE2, 1'b1);
        #1 chk_idle("stall_idle");
        step();
        #1 chk_beat("stall_b0", 2'd0, 8'hD0, 1'b0);
        step();
        set_src(0, 1'b0, 8'hD1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_gap_valid", {31'd0, out_valid}, 32'd0);
            chk("stall_gap_busy", {31'd0, busy}, 32'd1);
            chk("stall_gap_src", {30'd0, out_src}, 32'd0);
            chk("stall_gap_ready", {28'd0, req_ready}, 32'h1);
            step();
        end
        set_src(0, 1'b1, 8'hD1, 1'b0);
        #1 chk_beat("stall_b1", 2'd0, 8'hD1, 1'b0);
        step();
        set_src(0, 1'b1, 8'hD2, 1'b1);
        #1 chk_beat("stall_b2", 2'd0, 8'hD2, 1'b1);
        step();
        set_src(0, 1'b0, 8'h00, 1'b0);
        #1 chk_idle("stall_end");
        step();
        #1 chk_beat("stall_next", 2'd2, 8'hE2, 1'b1);
        step();
        set_src(2, 1'b0, 8'h00, 1'b0);

        // Reset pulse during beat 3 of a 5-beat frame from source 2 (ptr is 3 beforehand).
        set_src(2, 1'b1, 8'hF0, 1'b0);
        #1 chk_idle("mrst_idle");
        step();
        for (int k = 0; k < 2; k++) begin
            set_src(2, 1'b1, 8'hF0 + 8'(k), 1'b0);
            #1 chk_beat("mrst_beat", 2'd2, 8'hF0 + 8'(k), 1'b0);
            step();
        end
        set_src(2, 1'b1, 8'hF2, 1'b0);
        #1 chk_beat("mrst_pre", 2'd2, 8'hF2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_ready", {28'd0, req_ready}, 32'd0);
        chk("mrst_last",  {31'd0, out_last},  32'd0);
        chk("mrst_src",   {30'd0, out_src},   32'd0);
        chk("mrst_busy",  {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_src(2, 1'b0, 8'h00, 1'b0);
        set_src(0, 1'b1, 8'h5A, 1'b1);
        set_src(3, 1'b1, 8'h3C, 1'b1);
        #1 chk_idle("post_rst_idle");
        step();
        #1 chk_beat("post_rst_win", 2'd0, 8'h5A, 1'b1);
        step();
        req_valid = '0;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
